// File: rtl/result_matrix_accum.sv
// rtl/result_matrix_accum.sv - multi-lane result store with element-count accumulator FSM
// Optional feature macro RESULT_MINMAX_EN adds max_value/min_value over accumulated commits.
module result_matrix_accum #(
   parameter int ADDR_WIDTH   = 7,
   parameter int RESULT_WIDTH = 24,
   parameter int NUM_LANES    = 2,
   parameter int SUM_WIDTH    = RESULT_WIDTH + ADDR_WIDTH,
   parameter int NUM_ELEMENTS = 2**ADDR_WIDTH
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   input  logic [NUM_LANES-1:0]                write,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0]     addr,
   input  logic [NUM_LANES*RESULT_WIDTH-1:0]   data_in,
   output logic [NUM_LANES*RESULT_WIDTH-1:0]   data_out,
   output logic                                busy,
   output logic                                end_operation,
   output logic [SUM_WIDTH-1:0]                matrix_sum,
   output logic                                sum_overflow,
`ifdef RESULT_MINMAX_EN
   output logic [RESULT_WIDTH-1:0]             max_value,
   output logic [RESULT_WIDTH-1:0]             min_value,
`endif
   output logic [ADDR_WIDTH:0]                 elem_count
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   // Wide enough for the accumulator plus every lane's data, so the carry-out is never lost.
   localparam int EXT_W = SUM_WIDTH + RESULT_WIDTH + 3;
   localparam int CNT_W = ADDR_WIDTH + 3;
   localparam logic [ADDR_WIDTH:0] ELEM_MAX = NUM_ELEMENTS[ADDR_WIDTH:0];
   localparam logic [CNT_W-1:0]    ELEM_CMP = CNT_W'(NUM_ELEMENTS);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t state, state_next;

   logic [NUM_LANES-1:0]              stg_write;
   logic [NUM_LANES*ADDR_WIDTH-1:0]   stg_addr;
   logic [NUM_LANES*RESULT_WIDTH-1:0] stg_data;
   logic [RESULT_WIDTH-1:0]           mem [DEPTH];

   logic [SUM_WIDTH-1:0] acc;
   logic [EXT_W-1:0]     lane_sum;
   logic [EXT_W-1:0]     sum_full;
   logic [CNT_W-1:0]     lane_cnt;
   logic [CNT_W-1:0]     cnt_full;
   logic                 accum_commit;
   logic                 reach_end;

   always_ff @(posedge clock) begin
      if (reset) begin
         stg_write <= '0;
         stg_addr  <= '0;
         stg_data  <= '0;
      end else begin
         stg_write <= write;
         stg_addr  <= addr;
         stg_data  <= data_in;
      end
   end

   // Ascending lane order: the last assignment, i.e. the highest lane, wins on a shared address.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (stg_write[k])
               mem[stg_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= stg_data[k*RESULT_WIDTH +: RESULT_WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         for (int k = 0; k < NUM_LANES; k++)
            data_out[k*RESULT_WIDTH +: RESULT_WIDTH] <= mem[addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

   always_comb begin
      lane_sum = '0;
      lane_cnt = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (stg_write[k]) begin
            lane_sum = lane_sum + EXT_W'(stg_data[k*RESULT_WIDTH +: RESULT_WIDTH]);
            lane_cnt = lane_cnt + CNT_W'(1);
         end
      end
   end

   assign accum_commit = (state == S_ACCUM) && !start && (|stg_write);
   assign sum_full     = EXT_W'(acc) + lane_sum;
   assign cnt_full     = CNT_W'(elem_count) + lane_cnt;
   assign reach_end    = cnt_full >= ELEM_CMP;

   always_ff @(posedge clock) begin
      if (reset || start) begin
         acc          <= '0;
         sum_overflow <= 1'b0;
         elem_count   <= '0;
      end else if (accum_commit) begin
         acc <= sum_full[SUM_WIDTH-1:0];
         if (|sum_full[EXT_W-1:SUM_WIDTH])
            sum_overflow <= 1'b1;
         elem_count <= reach_end ? ELEM_MAX : cnt_full[ADDR_WIDTH:0];
      end
   end

`ifdef RESULT_MINMAX_EN
   logic [RESULT_WIDTH-1:0] max_r, min_r, max_nx, min_nx;

   always_comb begin
      max_nx = max_r;
      min_nx = min_r;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (stg_write[k]) begin
            if (stg_data[k*RESULT_WIDTH +: RESULT_WIDTH] > max_nx)
               max_nx = stg_data[k*RESULT_WIDTH +: RESULT_WIDTH];
            if (stg_data[k*RESULT_WIDTH +: RESULT_WIDTH] < min_nx)
               min_nx = stg_data[k*RESULT_WIDTH +: RESULT_WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || start) begin
         max_r <= '0;
         min_r <= '1;
      end else if (accum_commit) begin
         max_r <= max_nx;
         min_r <= min_nx;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (start)
         state_next = S_ACCUM;
      else if (accum_commit && reach_end)
         state_next = S_DONE;
   end

   always_comb begin
      busy          = (state == S_ACCUM);
      end_operation = (state == S_DONE);
      matrix_sum    = (state == S_DONE) ? acc : '0;
`ifdef RESULT_MINMAX_EN
      max_value     = (state == S_DONE) ? max_r : '0;
      min_value     = (state == S_DONE) ? min_r : '0;
`endif
   end

endmodule

// File: tb/tb_result_matrix_accum.sv
// tb/tb_result_matrix_accum.sv - directed bench with a transaction-level model for result_matrix_accum
// Covers RESULT_MINMAX_EN outputs when that macro is defined.
module tb_result_matrix_accum;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_i;
   logic [1:0]  write_i;
   logic [3:0]  addr_i;
   logic [15:0] din_i;

   logic [15:0] dout10, dout9;
   logic        busy10, busy9, end10, end9, ovf10, ovf9;
   logic [9:0]  sum10;
   logic [8:0]  sum9;
   logic [2:0]  cnt10, cnt9;
`ifdef RESULT_MINMAX_EN
   logic [7:0]  maxv10, minv10, maxv9, minv9;
`endif

   always #5 clock = ~clock;

   result_matrix_accum #(.ADDR_WIDTH(2), .RESULT_WIDTH(8), .NUM_LANES(2)) u_dut (
      .clock(clock), .reset(reset), .start(start_i), .write(write_i), .addr(addr_i),
      .data_in(din_i), .data_out(dout10), .busy(busy10), .end_operation(end10),
      .matrix_sum(sum10), .sum_overflow(ovf10),
`ifdef RESULT_MINMAX_EN
      .max_value(maxv10), .min_value(minv10),
`endif
      .elem_count(cnt10));

   result_matrix_accum #(.ADDR_WIDTH(2), .RESULT_WIDTH(8), .NUM_LANES(2), .SUM_WIDTH(9)) u_dut9 (
      .clock(clock), .reset(reset), .start(start_i), .write(write_i), .addr(addr_i),
      .data_in(din_i), .data_out(dout9), .busy(busy9), .end_operation(end9),
      .matrix_sum(sum9), .sum_overflow(ovf9),
`ifdef RESULT_MINMAX_EN
      .max_value(maxv9), .min_value(minv9),
`endif
      .elem_count(cnt9));

   int n_vec  = 0;
   int n_fail = 0;

   // Model: phase 0 idle, 1 accumulating, 2 done; true_sum is the unwrapped total.
   int     phase;
   longint true_sum;
   int     cnt, mmax, mmin;
   int     mem_m [4];
   bit     known [4];
   bit     p_wr [2];
   int     p_ad [2];
   int     p_dt [2];
   int     exp_dout [2];
   bit     dout_known [2];

   task automatic check(input string name, input logic [63:0] act, input longint exp);
      n_vec++;
      if (act !== 64'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic model_edge();
      int a, d;
      if (reset) begin
         phase = 0; true_sum = 0; cnt = 0; mmax = 0; mmin = 255;
         for (int l = 0; l < 2; l++) begin
            exp_dout[l] = 0; dout_known[l] = 1'b1; p_wr[l] = 1'b0;
         end
         return;
      end
      for (int l = 0; l < 2; l++) begin
         a = int'(addr_i[l*2 +: 2]);
         exp_dout[l]   = mem_m[a];
         dout_known[l] = known[a];
      end
      for (int l = 0; l < 2; l++) begin
         if (p_wr[l]) begin
            mem_m[p_ad[l]] = p_dt[l];
            known[p_ad[l]] = 1'b1;
         end
      end
      if (start_i) begin
         phase = 1; true_sum = 0; cnt = 0; mmax = 0; mmin = 255;
      end else if (phase == 1 && (p_wr[0] || p_wr[1])) begin
         for (int l = 0; l < 2; l++) begin
            if (p_wr[l]) begin
               true_sum += p_dt[l];
               cnt++;
               if (p_dt[l] > mmax) mmax = p_dt[l];
               if (p_dt[l] < mmin) mmin = p_dt[l];
            end
         end
         if (cnt >= 4) begin
            cnt = 4;
            phase = 2;
         end
      end
      for (int l = 0; l < 2; l++) begin
         p_wr[l] = write_i[l];
         p_ad[l] = int'(addr_i[l*2 +: 2]);
         d       = int'(din_i[l*8 +: 8]);
         p_dt[l] = d;
      end
   endtask

   task automatic compare_all();
      longint ms10, ms9;
      ms10 = (phase == 2) ? true_sum % 1024 : 0;
      ms9  = (phase == 2) ? true_sum % 512 : 0;
      check("busy",       64'(busy10), longint'(phase == 1));
      check("busy_w9",    64'(busy9),  longint'(phase == 1));
      check("end_op",     64'(end10),  longint'(phase == 2));
      check("end_op_w9",  64'(end9),   longint'(phase == 2));
      check("sum",        64'(sum10),  ms10);
      check("sum_w9",     64'(sum9),   ms9);
      check("ovf",        64'(ovf10),  longint'(true_sum >= 1024));
      check("ovf_w9",     64'(ovf9),   longint'(true_sum >= 512));
      check("count",      64'(cnt10),  cnt);
      check("count_w9",   64'(cnt9),   cnt);
      for (int l = 0; l < 2; l++) begin
         if (dout_known[l]) begin
            check("data_out",    64'(dout10[l*8 +: 8]), exp_dout[l]);
            check("data_out_w9", 64'(dout9[l*8 +: 8]),  exp_dout[l]);
         end
      end
`ifdef RESULT_MINMAX_EN
      check("max_value",    64'(maxv10), (phase == 2) ? mmax : 0);
      check("min_value",    64'(minv10), (phase == 2) ? mmin : 0);
      check("max_value_w9", 64'(maxv9),  (phase == 2) ? mmax : 0);
      check("min_value_w9", 64'(minv9),  (phase == 2) ? mmin : 0);
`endif
   endtask

   task automatic drive(input bit r, input bit s, input bit [1:0] w,
                        input int a0, input int d0, input int a1, input int d1);
      reset   = r;
      start_i = s;
      write_i = w;
      addr_i  = {2'(a1), 2'(a0)};
      din_i   = {8'(d1), 8'(d0)};
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         mem_m[i] = 0; known[i] = 1'b0;
      end
      @(negedge clock);
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      check("rst_busy", 64'(busy10), 0);
      check("rst_sum", 64'(sum10), 0);

      // Two-lane fill to completion.
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 2'b11, 0, 10, 1, 20);
      drive(0, 0, 2'b11, 2, 30, 3, 40);
      drive(0, 0, 2'b00, 0, 0, 1, 0);
      check("t1_end", 64'(end10), 1);
      check("t1_sum", 64'(sum10), 100);
      check("t1_count", 64'(cnt10), 4);
      check("t1_rd0", 64'(dout10[7:0]), 10);
      check("t1_rd1", 64'(dout10[15:8]), 20);
      drive(0, 0, 2'b00, 2, 0, 3, 0);
      check("t1_rd2", 64'(dout10[7:0]), 30);
      check("t1_rd3", 64'(dout10[15:8]), 40);

      // Same address from both lanes: highest lane wins, both counted.
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 2'b11, 1, 5, 1, 7);
      drive(0, 0, 2'b11, 2, 100, 3, 200);
      check("t2_count2", 64'(cnt10), 2);
      drive(0, 0, 2'b00, 1, 0, 0, 0);
      check("t2_mem1", 64'(dout10[7:0]), 7);
      check("t2_sum", 64'(sum10), 312);

      // Overflow on the 9-bit accumulator.
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 2'b11, 2, 255, 3, 255);
      drive(0, 0, 2'b11, 2, 255, 3, 255);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("t3_sum9", 64'(sum9), 508);
      check("t3_ovf9", 64'(ovf9), 1);
      check("t3_sum10", 64'(sum10), 1020);
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      check("t3_ovf_clr", 64'(ovf9), 0);
      check("t3_busy", 64'(busy9), 1);
      check("t3_sum_idle", 64'(sum9), 0);

      // Count saturation: 3 singles then a double reaches 5 -> held at 4.
      drive(0, 0, 2'b01, 1, 1, 0, 0);
      drive(0, 0, 2'b01, 1, 2, 0, 0);
      drive(0, 0, 2'b01, 1, 3, 0, 0);
      drive(0, 0, 2'b11, 2, 4, 3, 5);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("sat_count", 64'(cnt10), 4);
      check("sat_sum", 64'(sum10), 15);

      // A commit on the start edge writes the array but is not summed.
      drive(0, 0, 2'b11, 0, 50, 1, 60);
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      check("st_count", 64'(cnt10), 0);
      drive(0, 0, 2'b00, 0, 0, 1, 0);
      check("st_rd0", 64'(dout10[7:0]), 50);
      check("st_rd1", 64'(dout10[15:8]), 60);

      // Reset while a write is staged.
      drive(0, 0, 2'b01, 0, 77, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      check("t4_busy", 64'(busy10), 0);
      check("t4_dout", 64'(dout10), 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("t4_mem0", 64'(dout10[7:0]), 50);

      // Idle writes reach the array only; a same-edge commit is not visible to the read.
      drive(0, 0, 2'b01, 0, 9, 0, 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("t5_readold", 64'(dout10[7:0]), 50);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("t5_mem0", 64'(dout10[7:0]), 9);
      check("t5_count", 64'(cnt10), 0);

      // Min/max operation, then restart from DONE.
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 2'b11, 0, 10, 1, 3);
      drive(0, 0, 2'b11, 2, 250, 3, 7);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      check("t6_sum", 64'(sum10), 270);
`ifdef RESULT_MINMAX_EN
      check("t6_max", 64'(maxv10), 250);
      check("t6_min", 64'(minv10), 3);
`endif
      drive(0, 1, 2'b00, 0, 0, 0, 0);
      check("t5_restart_busy", 64'(busy10), 1);
      check("t5_restart_sum", 64'(sum10), 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
